// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a load/ready handshake and sends it LSB first.
// Latency: first bit one bit-time (DIV cycles) after acceptance; done pulses one cycle after the final bit.
// Backpressure: ready is high only in IDLE; load while busy is ignored and the current frame is untouched.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous reset, active low
//   load     send request, accepted on an edge where load && ready
//   din      word to send, sampled only on the accepting edge
//   ready    combinational, high in IDLE
//   shr      registered one-cycle strobe marking each valid bit on shr_out
//   shr_out  registered serial data (holds between strobes)
//   busy     combinational, high outside IDLE
//   done     registered one-cycle pulse after the last bit of a frame
//
// Optional feature: define PARITY_EN to append an even-parity bit (XOR of the
// captured word) as an extra strobed bit after the WIDTH data bits.

module piso_serializer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             shr,
    output logic             shr_out,
    output logic             busy,
    output logic             done
);

`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    // Keep the divider counter at least one bit wide so DIV=1 still elaborates.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               shr_q,     shr_d;
    logic               shr_out_q, shr_out_d;
    logic               done_q,    done_d;
`ifdef PARITY_EN
    logic               parity_q,  parity_d;
`endif

    logic tick;
    logic last_bit;

    assign tick     = (div_cnt_q == DIV_W'(DIV - 1));
    assign last_bit = (bit_cnt_q == CNT_W'(NBITS - 1));

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        shr_d     = 1'b0;
        shr_out_d = shr_out_q;
        done_d    = 1'b0;
`ifdef PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
`ifdef PARITY_EN
                    parity_d  = ^din;
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    div_cnt_d = '0;
                    shr_d     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef PARITY_EN
                    // Data bits first; the slot after them carries the parity bit.
                    if (bit_cnt_q < CNT_W'(WIDTH)) begin
                        shr_out_d = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end else begin
                        shr_out_d = parity_q;
                    end
`else
                    shr_out_d = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
`endif
                    if (last_bit) begin
                        state_d = DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            shr_q     <= 1'b0;
            shr_out_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            shr_q     <= shr_d;
            shr_out_q <= shr_out_d;
            done_q    <= done_d;
`ifdef PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign shr     = shr_q;
    assign shr_out = shr_out_q;
    assign done    = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (DIV=1 and DIV=3) driven with directed words.
// The driver pushes expected strobe/done events with their edge numbers; a monitor pops and compares.
// The monitor also loops shr_out back into a 4-bit MSB-entry receiver and checks the word at done.

module tb_piso_serializer;

    localparam int W    = 4;
    localparam int DIV0 = 1;
    localparam int DIV1 = 3;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    typedef struct {
        logic         is_done;
        logic         val;
        int           cyc;
        logic [W-1:0] word;
    } exp_t;

    logic         clk;
    logic         clr;
    logic         load0, load1;
    logic [W-1:0] din0, din1;
    logic         ready0, shr0, so0, busy0, done0;
    logic         ready1, shr1, so1, busy1, done1;

    exp_t         q0[$];
    exp_t         q1[$];
    int           cyc;
    int           errors;
    int           checks;
    logic [W-1:0] rx[2];
    int           nstr[2];
    logic         last[2];

    piso_serializer #(.WIDTH(W), .DIV(DIV0)) u_dut0 (
        .clk(clk), .clr(clr), .load(load0), .din(din0),
        .ready(ready0), .shr(shr0), .shr_out(so0), .busy(busy0), .done(done0)
    );

    piso_serializer #(.WIDTH(W), .DIV(DIV1)) u_dut1 (
        .clk(clk), .clr(clr), .load(load1), .din(din1),
        .ready(ready1), .shr(shr1), .shr_out(so1), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc == k after rising edge k.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Expected events for a frame accepted at edge a; 'full' = 0 keeps only the first two bits.
    task automatic push_frame(input int k, input logic [W-1:0] d, input int a, input bit full);
        int   dv;
        int   nbits;
        exp_t e;
        dv    = (k == 0) ? DIV0 : DIV1;
        nbits = full ? W : 2;
        for (int i = 0; i < nbits; i++) begin
            e = '{1'b0, d[i], a + dv * (i + 1), d};
            push_ev(k, e);
        end
        if (full) begin
`ifdef PARITY_EN
            e = '{1'b0, ^d, a + dv * (W + 1), d};
            push_ev(k, e);
`endif
            e = '{1'b1, 1'b0, a + dv * NB + 1, d};
            push_ev(k, e);
        end
    endtask

    task automatic mon(input int k, input logic s, input logic so, input logic d);
        exp_t e;
        bit   empty;
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        e     = '{1'b0, 1'b0, 0, '0};
        if (s || d) begin
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected event: shr=%0b done=%0b required none (cycle %0d)",
                         k, s, d, cyc);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d event kind(done)", k), 32'(d), 32'(e.is_done));
                chk($sformatf("dut%0d event edge", k), cyc, e.cyc);
                if (!e.is_done) chk($sformatf("dut%0d shr_out", k), 32'(so), 32'(e.val));
            end
            if (s) begin
                if (nstr[k] < W) rx[k] = {so, rx[k][W-1:1]};
                nstr[k]++;
                last[k] = so;
            end
            if (d) begin
                if (!empty) chk($sformatf("dut%0d loopback word", k), 32'(rx[k]), 32'(e.word));
                nstr[k] = 0;
            end
        end else begin
            chk($sformatf("dut%0d shr_out hold", k), 32'(so), 32'(last[k]));
        end
    endtask

    always @(negedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < 2; k++) begin
                rx[k]   = '0;
                nstr[k] = 0;
                last[k] = 1'b0;
            end
        end else begin
            mon(0, shr0, so0, done0);
            mon(1, shr1, so1, done1);
        end
    end

    task automatic send(input int k, input logic [W-1:0] d, input bit full);
        int a;
        int n;
        n = 0;
        while (((k == 0) ? ready0 : ready1) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL dut%0d ready timeout: ready=0 required 1", k);
        end
        if (k == 0) begin load0 = 1'b1; din0 = d; end
        else        begin load1 = 1'b1; din1 = d; end
        a = cyc + 1;
        push_frame(k, d, a, full);
        @(negedge clk);
        if (k == 0) begin
            load0 = 1'b0;
            chk("dut0 busy after accept", 32'(busy0), 1);
            chk("dut0 ready after accept", 32'(ready0), 0);
        end else begin
            load1 = 1'b0;
            chk("dut1 busy after accept", 32'(busy1), 1);
            chk("dut1 ready after accept", 32'(ready1), 0);
        end
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (((k == 0) ? q0.size() : q1.size()) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d pending events", k), (k == 0) ? q0.size() : q1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a;
        cyc    = 0;
        errors = 0;
        checks = 0;
        for (int k = 0; k < 2; k++) begin
            rx[k]   = '0;
            nstr[k] = 0;
            last[k] = 1'b0;
        end
        clr   = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        din0  = '0;
        din1  = '0;

        #1;
        chk("reset ready0", 32'(ready0), 1);
        chk("reset busy0", 32'(busy0), 0);
        chk("reset shr0", 32'(shr0), 0);
        chk("reset shr_out0", 32'(so0), 0);
        chk("reset done0", 32'(done0), 0);
        chk("reset ready1", 32'(ready1), 1);
        chk("reset busy1", 32'(busy1), 0);
        chk("reset shr1", 32'(shr1), 0);
        chk("reset shr_out1", 32'(so1), 0);
        chk("reset done1", 32'(done1), 0);

        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Basic frame: bits 1,1,0,1 on edges a+1..a+4, done at a+5.
        send(0, 4'b1011, 1'b1);
        drain(0);

        // Loop-back word check.
        send(0, 4'b0110, 1'b1);
        drain(0);

        // Divided bit rate: strobes every third edge.
        send(1, 4'b1001, 1'b1);
        drain(1);

        // load held high, din changed mid-frame; second frame accepted at a+NB+2.
        load0 = 1'b1;
        din0  = 4'b1100;
        a     = cyc + 1;
        push_frame(0, 4'b1100, a, 1'b1);
        push_frame(0, 4'b0011, a + NB + 2, 1'b1);
        @(negedge clk);
        din0 = 4'b1111;
        while (cyc < a + 2) @(negedge clk);
        din0 = 4'b0011;
        while (cyc < a + NB + 2) @(negedge clk);
        load0 = 1'b0;
        din0  = 4'b1010;
        drain(0);

        // Word whose parity bit is 1 when parity is built.
        send(0, 4'b0111, 1'b1);
        drain(0);

        // Abort during the second bit: only two strobes, no done.
        load0 = 1'b1;
        din0  = 4'b0101;
        a     = cyc + 1;
        push_frame(0, 4'b0101, a, 1'b0);
        @(negedge clk);
        load0 = 1'b0;
        while (cyc < a + 2) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("abort shr", 32'(shr0), 0);
        chk("abort shr_out", 32'(so0), 0);
        chk("abort ready", 32'(ready0), 1);
        chk("abort busy", 32'(busy0), 0);
        chk("abort done", 32'(done0), 0);
        #1 clr = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort pending events", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
